lam_ctrl: RTL and testbench
===========================

Name: lam_ctrl

Overview:
- Execute-side consumer of the load/store (lam_*) fields registered by the decode/execute pipeline latch.
- Turns one lam_new request into a single memory transaction over a req/ack handshake.
- For loads, aligns and extends the read data and writes it back to the register file.
- Drives stall to the pipeline latch enables while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: ack watchdog limit; used only with LAM_TIMEOUT_EN.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lam_new  in  1  new load/store request; sampled only in IDLE.
- lam_rw  in  1  1 = store, 0 = load.
- lam_type  in  3  funct3 access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- lam_sel_out  in  5  destination register index for a load.
- addr  in  ADDR_W  effective byte address (ALU result).
- st_data  in  32  store data, already read from the register file.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits = 0.
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-positioned store data.
- mem_ack  in  1  memory completion, one-cycle pulse.
- mem_rdata  in  32  read word; valid while mem_ack = 1.
- stall  out  1  hold the upstream pipeline latches.
- rf_we  out  1  register-file write strobe.
- rf_sel  out  5  register-file write index.
- rf_data  out  32  register-file write data.
- lam_err  out  1  one-cycle pulse on a misaligned or illegal-type access.

Behaviour:
- Reset, asynchronous, when reset = 0: state = IDLE; every registered output is 0, including mem_req, mem_we, mem_addr, mem_be, mem_wdata, rf_we, rf_sel, rf_data and lam_err. A reset asserted mid-transaction drops mem_req immediately, and any late mem_ack is ignored.
- FSM states: IDLE, REQ, WB.
- IDLE, lam_new = 1:
  - Capture rw, type, sel_out and addr[1:0].
  - Compute mem_addr = {addr[ADDR_W-1:2], 2'b00}, plus mem_be and mem_wdata.
  - Legal access: go to REQ.
  - Misaligned access (H with addr[0] = 1, W with addr[1:0] != 0) or illegal type (011, 11x): pulse lam_err on the next cycle, issue no memory access, stay in IDLE.
- REQ: mem_req = 1 and the captured address, enables and data are held stable until mem_ack.
  - mem_ack on a store: go to IDLE.
  - mem_ack on a load: register the extracted data and go to WB.
- WB: one cycle with rf_we = 1, rf_sel = captured sel_out, rf_data = extended data; then go to IDLE.
  - If sel_out = 0, rf_we stays 0 (x0 is never written).
- stall (combinational) = (state == IDLE && lam_new) || state == REQ. It is not asserted in WB.
- Store lane rules:
  - B: be = 1 << addr[1:0]; wdata = st_data[7:0] replicated to all 4 lanes.
  - H: be = 0011 or 1100 according to addr[1]; wdata = st_data[15:0] replicated.
  - W: be = 1111; wdata = st_data.
- Load extraction: select the byte or halfword by the captured addr[1:0]. Types B and H sign-extend; BU and HU zero-extend.
- Latency:
  - Zero-wait memory (ack in the first REQ cycle): store takes 2 cycles from lam_new; load writes back in cycle 3.
  - Each extra wait cycle adds 1.
- lam_new while not in IDLE: ignored. Upstream is stalled, so it cannot be a new request.
- mem_ack while in IDLE or WB: ignored.

Optional Feature:
- Macro: LAM_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to REQ and increments every REQ cycle.
  - When it reaches TIMEOUT_CYCLES without mem_ack: drop mem_req, pulse lam_err, skip writeback, return to IDLE.
  - An ack in the same cycle as the timeout wins, and the access completes normally.
- Undefined: no counter; REQ waits indefinitely.

Decomposition:
- Shared package:
  - lam_type encodings: LAM_B, LAM_H, LAM_W, LAM_BU, LAM_HU.
  - FSM state enum.
  - LAM_RW_STORE / LAM_RW_LOAD constants.
- One natural sub-module, lam_align: combinational store lane and byte-enable generation plus load extract/extend. It is shared by the request and writeback paths.

Test Plan:
- LW addr = 0x1008, sel_out = 5, ack in the first REQ cycle, rdata = 0xDEADBEEF -> mem_addr = 0x1008, be = 1111, stall high for 2 cycles, then rf_we = 1, rf_sel = 5, rf_data = 0xDEADBEEF.
- LB addr = 0x2003, rdata = 0x80FF_1234 -> rf_data = 0xFFFFFF80. The same access as LBU -> rf_data = 0x00000080.
- SH addr = 0x3002, st_data = 0x0000ABCD, ack after 3 wait cycles -> be = 1100, wdata = 0xABCDABCD, mem_req held for 4 cycles, no rf_we.
- LW addr = 0x4001 -> lam_err pulses once, mem_req never asserted, FSM back in IDLE. LH with sel_out = 0 and a legal address -> memory access occurs, rf_we stays 0.
- reset driven low during REQ -> mem_req = 0 immediately, all outputs 0; a subsequent mem_ack produces no rf_we.
- With LAM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack -> mem_req drops after 4 REQ cycles and lam_err pulses once. An ack arriving exactly in the 4th cycle completes the access normally.

Source files
------------

// File: rtl/lam_ctrl_pkg.sv
// lam_ctrl_pkg: shared encodings for the load/store controller.
// Holds the funct3 access types, read/write direction constants, the FSM
// state type and the access legality rule used by the alignment logic.
package lam_ctrl_pkg;

    // funct3 access types
    localparam logic [2:0] LAM_B  = 3'b000;
    localparam logic [2:0] LAM_H  = 3'b001;
    localparam logic [2:0] LAM_W  = 3'b010;
    localparam logic [2:0] LAM_BU = 3'b100;
    localparam logic [2:0] LAM_HU = 3'b101;

    // lam_rw direction
    localparam logic LAM_RW_STORE = 1'b1;
    localparam logic LAM_RW_LOAD  = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } lam_state_e;

    // An access is legal when its type is a known encoding and the byte
    // offset is naturally aligned for its size.
    function automatic logic lam_access_ok(input logic [2:0] acc_type,
                                           input logic [1:0] byte_off);
        logic ok;
        case (acc_type)
            LAM_B, LAM_BU: ok = 1'b1;
            LAM_H, LAM_HU: ok = ~byte_off[0];
            LAM_W:         ok = (byte_off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lam_align.sv
// lam_align: combinational lane steering for the load/store controller.
// Produces store byte enables and lane-replicated store data, extracts and
// sign/zero-extends load data, and flags illegal or misaligned accesses.
module lam_align
    import lam_ctrl_pkg::*;
(
    input  logic [2:0]  acc_type,
    input  logic [1:0]  byte_off,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rd_ext,
    output logic        ok
);

    // Extension helpers; sgn selects sign extension, otherwise zero.
    function automatic logic [31:0] ext_byte(input logic [7:0] v, input logic sgn);
        return {{24{sgn & v[7]}}, v};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] v, input logic sgn);
        return {{16{sgn & v[15]}}, v};
    endfunction

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        rd_sgn;

    // Store lanes: size comes from funct3[1:0], B/H data replicated to every lane.
    always_comb begin
        ok    = lam_access_ok(acc_type, byte_off);
        be    = 4'b1111;
        wdata = st_data;
        case (acc_type[1:0])
            2'b00: begin
                be    = 4'b0001 << byte_off;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                be    = byte_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    // Load extract: pick the addressed byte/halfword, funct3[2] means unsigned.
    always_comb begin
        rd_byte = rd_word[{byte_off, 3'b000} +: 8];
        rd_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
        rd_sgn  = ~acc_type[2];
        case (acc_type[1:0])
            2'b00:   rd_ext = ext_byte(rd_byte, rd_sgn);
            2'b01:   rd_ext = ext_half(rd_half, rd_sgn);
            default: rd_ext = rd_word;
        endcase
    end

endmodule

// File: rtl/lam_ctrl.sv
// lam_ctrl: execute-side load/store controller.
// Turns a lam_new request into one req/ack memory transaction, writes load
// data back to the register file and stalls upstream while busy.
// Optional ack watchdog enabled by defining LAM_TIMEOUT_EN.
module lam_ctrl
    import lam_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lam_new,
    input  logic              lam_rw,
    input  logic [2:0]        lam_type,
    input  logic [4:0]        lam_sel_out,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       st_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic              rf_we,
    output logic [4:0]        rf_sel,
    output logic [31:0]       rf_data,
    output logic              lam_err
);

    // A watchdog limit below one cycle is meaningless; reject it at elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("lam_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    lam_state_e        state_q, state_d;
    logic [2:0]        type_q, type_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        sel_q, sel_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_sel_q, rf_sel_d;
    logic [31:0]       rf_data_q, rf_data_d;
    logic              lam_err_q, lam_err_d;

`ifdef LAM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    // The aligner sees live inputs while idle and the captured access afterwards.
    logic [2:0]  al_type;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rd_ext;
    logic        al_ok;

    assign al_type = (state_q == ST_IDLE) ? lam_type  : type_q;
    assign al_off  = (state_q == ST_IDLE) ? addr[1:0] : off_q;

    lam_align u_align (
        .acc_type (al_type),
        .byte_off (al_off),
        .st_data  (st_data),
        .rd_word  (mem_rdata),
        .be       (al_be),
        .wdata    (al_wdata),
        .rd_ext   (al_rd_ext),
        .ok       (al_ok)
    );

    // Next-state and next-output logic for the IDLE -> REQ -> WB sequence.
    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        off_d       = off_q;
        sel_d       = sel_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rf_we_d     = 1'b0;
        rf_sel_d    = rf_sel_q;
        rf_data_d   = rf_data_q;
        lam_err_d   = 1'b0;
`ifdef LAM_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (lam_new) begin
                    if (al_ok) begin
                        state_d     = ST_REQ;
                        type_d      = lam_type;
                        off_d       = addr[1:0];
                        sel_d       = lam_sel_out;
                        mem_req_d   = 1'b1;
                        mem_we_d    = lam_rw;
                        mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
`ifdef LAM_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        lam_err_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'b0000;
                    if (mem_we_q == LAM_RW_STORE) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_WB;
                        rf_we_d   = (sel_q != 5'd0);
                        rf_sel_d  = sel_q;
                        rf_data_d = al_rd_ext;
                    end
                end
`ifdef LAM_TIMEOUT_EN
                // An ack in the final watchdog cycle is taken by the branch above.
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_be_d  = 4'b0000;
                    lam_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            type_q      <= 3'b000;
            off_q       <= 2'b00;
            sel_q       <= 5'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
            rf_we_q     <= 1'b0;
            rf_sel_q    <= 5'd0;
            rf_data_q   <= 32'h0;
            lam_err_q   <= 1'b0;
`ifdef LAM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            off_q       <= off_d;
            sel_q       <= sel_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rf_we_q     <= rf_we_d;
            rf_sel_q    <= rf_sel_d;
            rf_data_q   <= rf_data_d;
            lam_err_q   <= lam_err_d;
`ifdef LAM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Stall covers the request cycle itself and every REQ cycle, not WB.
    assign stall     = ((state_q == ST_IDLE) && lam_new) || (state_q == ST_REQ);

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign rf_we     = rf_we_q;
    assign rf_sel    = rf_sel_q;
    assign rf_data   = rf_data_q;
    assign lam_err   = lam_err_q;

endmodule

// File: tb/tb_lam_ctrl.sv
// tb_lam_ctrl: self-checking bench for lam_ctrl (table vectors, random
// transactions against a behavioural model, reset and watchdog sequences).
`timescale 1ns/1ps
module tb_lam_ctrl;

    localparam int ADDR_W = 32;
    localparam int TO     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        lam_new, lam_rw;
    logic [2:0]  lam_type;
    logic [4:0]  lam_sel_out;
    logic [31:0] addr, st_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall, rf_we;
    logic [4:0]  rf_sel;
    logic [31:0] rf_data;
    logic        lam_err;

    always #5 clk = ~clk;

    lam_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .lam_new(lam_new), .lam_rw(lam_rw),
        .lam_type(lam_type), .lam_sel_out(lam_sel_out), .addr(addr),
        .st_data(st_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
        .rf_we(rf_we), .rf_sel(rf_sel), .rf_data(rf_data), .lam_err(lam_err)
    );

    typedef struct {
        logic        rw;
        logic [2:0]  typ;
        logic [4:0]  sel;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] rdata;
        int          waits;   // wait cycles before ack; large = never
    } txn_t;

    typedef struct {
        int          err_cnt;
        int          req_cnt;
        int          stall_cnt;
        int          rfwe_cnt;
        int          unstable;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [4:0]  rf_sel;
        logic [31:0] rf_data;
    } obs_t;

    typedef struct {
        txn_t t;
        obs_t e;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic txn_t mk_t(input logic rw, input logic [2:0] typ, input logic [4:0] sel,
                                  input logic [31:0] a, input logic [31:0] st,
                                  input logic [31:0] rd, input int waits);
        txn_t t;
        t.rw = rw; t.typ = typ; t.sel = sel; t.addr = a; t.st = st; t.rdata = rd; t.waits = waits;
        return t;
    endfunction

    function automatic obs_t mk_e(input int err, input int req, input int stl, input int rfwe,
                                  input logic [31:0] a, input logic [3:0] be, input logic we,
                                  input logic [31:0] wd, input logic [4:0] sel, input logic [31:0] rd);
        obs_t e;
        e = '{default: 0};
        e.err_cnt = err; e.req_cnt = req; e.stall_cnt = stl; e.rfwe_cnt = rfwe;
        e.addr = a; e.be = be; e.we = we; e.wdata = wd; e.rf_sel = sel; e.rf_data = rd;
        return e;
    endfunction

    // Behavioural reference: access size, natural alignment and arithmetic lane math.
    function automatic obs_t model(input txn_t t);
        obs_t   e;
        int     size;
        int     off;
        logic   sgn;
        int     req;
        longint lv;
        e    = '{default: 0};
        off  = int'(t.addr[1:0]);
        sgn  = 1'b0;
        case (t.typ)
            3'd0:    begin size = 1; sgn = 1'b1; end
            3'd1:    begin size = 2; sgn = 1'b1; end
            3'd2:    size = 4;
            3'd4:    size = 1;
            3'd5:    size = 2;
            default: size = 0;
        endcase
        if (size == 0 || (off % size) != 0) begin
            e.err_cnt   = 1;
            e.stall_cnt = 1;
            return e;
        end
        e.addr = t.addr & ~32'h3;
        e.be   = 4'(((1 << size) - 1) << off);
        e.we   = t.rw;
        if (t.rw)
            e.wdata = (size == 4) ? t.st :
                      (size == 2) ? (t.st & 32'hFFFF) * 32'h0001_0001 :
                                    (t.st & 32'hFF) * 32'h0101_0101;
        req = t.waits + 1;
`ifdef LAM_TIMEOUT_EN
        if (req > TO) begin
            e.err_cnt   = 1;
            e.req_cnt   = TO;
            e.stall_cnt = TO + 1;
            return e;
        end
`endif
        e.req_cnt   = req;
        e.stall_cnt = req + 1;
        if (!t.rw && t.sel != 5'd0) begin
            lv = longint'({32'h0, t.rdata >> (8 * off)}) & ((longint'(1) << (8 * size)) - 1);
            if (sgn && lv >= (longint'(1) << (8 * size - 1)))
                lv = lv - (longint'(1) << (8 * size));
            e.rfwe_cnt = 1;
            e.rf_sel   = t.sel;
            e.rf_data  = lv[31:0];
        end
        return e;
    endfunction

    // Drive one request starting at posedge+1 and observe a fixed window.
    task automatic do_txn(input txn_t t, output obs_t o);
        int window;
        o = '{default: 0};
        window = t.waits + 6;
        lam_new = 1'b1; lam_rw = t.rw; lam_type = t.typ; lam_sel_out = t.sel;
        addr = t.addr; st_data = t.st;
        @(negedge clk);
        if (stall) o.stall_cnt++;
        if (lam_err) o.err_cnt++;
        @(posedge clk); #1;
        lam_new = 1'b0;
        lam_rw = 1'($urandom); lam_type = 3'($urandom); lam_sel_out = 5'($urandom);
        addr = $urandom; st_data = $urandom;
        for (int c = 0; c < window; c++) begin
            @(negedge clk);
            if (stall) o.stall_cnt++;
            if (lam_err) o.err_cnt++;
            if (rf_we) begin
                o.rfwe_cnt++;
                o.rf_sel  = rf_sel;
                o.rf_data = rf_data;
            end
            if (mem_req) begin
                o.req_cnt++;
                if (o.req_cnt == 1) begin
                    o.addr = mem_addr; o.be = mem_be; o.we = mem_we; o.wdata = mem_wdata;
                end else if (mem_addr !== o.addr || mem_be !== o.be ||
                             mem_we !== o.we || mem_wdata !== o.wdata) begin
                    o.unstable++;
                end
                if (o.req_cnt == t.waits + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = t.rdata;
                end
            end
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            // Stray lam_new while in REQ must be ignored.
            lam_new   = mem_req ? 1'($urandom) : 1'b0;
        end
        lam_new = 1'b0;
    endtask

    task automatic compare(input string tag, input obs_t o, input obs_t e);
        check({tag, ".err"},   o.err_cnt,   e.err_cnt);
        check({tag, ".req"},   o.req_cnt,   e.req_cnt);
        check({tag, ".stall"}, o.stall_cnt, e.stall_cnt);
        check({tag, ".rfwe"},  o.rfwe_cnt,  e.rfwe_cnt);
        if (e.req_cnt > 0) begin
            check({tag, ".addr"},   o.addr, e.addr);
            check({tag, ".be"},     {28'h0, o.be}, {28'h0, e.be});
            check({tag, ".we"},     {31'h0, o.we}, {31'h0, e.we});
            check({tag, ".stable"}, o.unstable, 0);
            if (e.we) check({tag, ".wdata"}, o.wdata, e.wdata);
        end
        if (e.rfwe_cnt > 0) begin
            check({tag, ".rf_sel"},  {27'h0, o.rf_sel}, {27'h0, e.rf_sel});
            check({tag, ".rf_data"}, o.rf_data, e.rf_data);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mem_req"},   {31'h0, mem_req}, 0);
        check({tag, ".mem_we"},    {31'h0, mem_we}, 0);
        check({tag, ".mem_addr"},  mem_addr, 0);
        check({tag, ".mem_be"},    {28'h0, mem_be}, 0);
        check({tag, ".mem_wdata"}, mem_wdata, 0);
        check({tag, ".rf_we"},     {31'h0, rf_we}, 0);
        check({tag, ".rf_sel"},    {27'h0, rf_sel}, 0);
        check({tag, ".rf_data"},   rf_data, 0);
        check({tag, ".lam_err"},   {31'h0, lam_err}, 0);
        check({tag, ".stall"},     {31'h0, stall}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[15];
        obs_t o;
        txn_t t;

        vt[0]  = '{t: mk_t(0, 3'd2, 5'd5,  32'h1008, 32'h0, 32'hDEADBEEF, 0),
                   e: mk_e(0, 1, 2, 1, 32'h1008, 4'hF, 0, 32'h0, 5'd5, 32'hDEADBEEF)};
        vt[1]  = '{t: mk_t(0, 3'd0, 5'd7,  32'h2003, 32'h0, 32'h80FF1234, 0),
                   e: mk_e(0, 1, 2, 1, 32'h2000, 4'h8, 0, 32'h0, 5'd7, 32'hFFFFFF80)};
        vt[2]  = '{t: mk_t(0, 3'd4, 5'd7,  32'h2003, 32'h0, 32'h80FF1234, 0),
                   e: mk_e(0, 1, 2, 1, 32'h2000, 4'h8, 0, 32'h0, 5'd7, 32'h00000080)};
        vt[3]  = '{t: mk_t(1, 3'd1, 5'd31, 32'h3002, 32'h0000ABCD, 32'h0, 3),
                   e: mk_e(0, 4, 5, 0, 32'h3000, 4'hC, 1, 32'hABCDABCD, 5'd0, 32'h0)};
        vt[4]  = '{t: mk_t(0, 3'd2, 5'd5,  32'h4001, 32'h0, 32'h0, 0),
                   e: mk_e(1, 0, 1, 0, 32'h0, 4'h0, 0, 32'h0, 5'd0, 32'h0)};
        vt[5]  = '{t: mk_t(0, 3'd1, 5'd0,  32'h5002, 32'h0, 32'h80017FFF, 0),
                   e: mk_e(0, 1, 2, 0, 32'h5000, 4'hC, 0, 32'h0, 5'd0, 32'h0)};
        vt[6]  = '{t: mk_t(1, 3'd0, 5'd3,  32'h6001, 32'h123456A5, 32'h0, 1),
                   e: mk_e(0, 2, 3, 0, 32'h6000, 4'h2, 1, 32'hA5A5A5A5, 5'd0, 32'h0)};
        vt[7]  = '{t: mk_t(1, 3'd2, 5'd3,  32'h7000, 32'hCAFEF00D, 32'h0, 0),
                   e: mk_e(0, 1, 2, 0, 32'h7000, 4'hF, 1, 32'hCAFEF00D, 5'd0, 32'h0)};
        vt[8]  = '{t: mk_t(0, 3'd5, 5'd3,  32'h8002, 32'h0, 32'h80017FFF, 2),
                   e: mk_e(0, 3, 4, 1, 32'h8000, 4'hC, 0, 32'h0, 5'd3, 32'h00008001)};
        vt[9]  = '{t: mk_t(0, 3'd1, 5'd9,  32'h8002, 32'h0, 32'h80017FFF, 0),
                   e: mk_e(0, 1, 2, 1, 32'h8000, 4'hC, 0, 32'h0, 5'd9, 32'hFFFF8001)};
        vt[10] = '{t: mk_t(0, 3'd1, 5'd9,  32'h8000, 32'h0, 32'h80017FFF, 0),
                   e: mk_e(0, 1, 2, 1, 32'h8000, 4'h3, 0, 32'h0, 5'd9, 32'h00007FFF)};
        vt[11] = '{t: mk_t(0, 3'd3, 5'd1,  32'h9000, 32'h0, 32'h0, 0),
                   e: mk_e(1, 0, 1, 0, 32'h0, 4'h0, 0, 32'h0, 5'd0, 32'h0)};
        vt[12] = '{t: mk_t(0, 3'd6, 5'd1,  32'h9000, 32'h0, 32'h0, 0),
                   e: mk_e(1, 0, 1, 0, 32'h0, 4'h0, 0, 32'h0, 5'd0, 32'h0)};
        vt[13] = '{t: mk_t(1, 3'd1, 5'd1,  32'h3001, 32'h1234, 32'h0, 0),
                   e: mk_e(1, 0, 1, 0, 32'h0, 4'h0, 0, 32'h0, 5'd0, 32'h0)};
        vt[14] = '{t: mk_t(0, 3'd0, 5'd12, 32'hA001, 32'h0, 32'h12347F56, 1),
                   e: mk_e(0, 2, 3, 1, 32'hA000, 4'h2, 0, 32'h0, 5'd12, 32'h0000007F)};

        reset = 1'b0; lam_new = 1'b0; lam_rw = 1'b0; lam_type = 3'd0; lam_sel_out = 5'd0;
        addr = 32'h0; st_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            do_txn(vt[i].t, o);
            compare($sformatf("vec%0d", i), o, vt[i].e);
        end

        // Watchdog behaviour
`ifdef LAM_TIMEOUT_EN
        do_txn(mk_t(0, 3'd2, 5'd6, 32'hB000, 32'h0, 32'h11112222, 50), o);
        check("tmo.req",  o.req_cnt, TO);
        check("tmo.err",  o.err_cnt, 1);
        check("tmo.rfwe", o.rfwe_cnt, 0);
        do_txn(mk_t(0, 3'd2, 5'd6, 32'hB004, 32'h0, 32'h33334444, TO - 1), o);
        check("tmo_ack.req",  o.req_cnt, TO);
        check("tmo_ack.err",  o.err_cnt, 0);
        check("tmo_ack.rfwe", o.rfwe_cnt, 1);
        check("tmo_ack.data", o.rf_data, 32'h33334444);
`else
        do_txn(mk_t(0, 3'd2, 5'd6, 32'hB000, 32'h0, 32'h11112222, 12), o);
        check("longwait.req",  o.req_cnt, 13);
        check("longwait.err",  o.err_cnt, 0);
        check("longwait.rfwe", o.rfwe_cnt, 1);
        check("longwait.data", o.rf_data, 32'h11112222);
`endif

        // Reset in the middle of REQ, then a late ack
        lam_new = 1'b1; lam_rw = 1'b0; lam_type = 3'd2; lam_sel_out = 5'd4;
        addr = 32'h0000C000; st_data = 32'h0;
        @(posedge clk); #1;
        lam_new = 1'b0;
        @(posedge clk); #1;
        check("rstmid.pre_req", {31'h0, mem_req}, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all_zero("rstmid");
        @(posedge clk); #1;
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rstmid.late_rfwe%0d", c), {31'h0, rf_we}, 0);
            check($sformatf("rstmid.late_req%0d", c),  {31'h0, mem_req}, 0);
        end
        @(posedge clk); #1;
        do_txn(vt[0].t, o);
        compare("post_reset", o, vt[0].e);

        // Randomized transactions against the model
        for (int i = 0; i < 60; i++) begin
            t = mk_t(1'($urandom), 3'($urandom), 5'($urandom), $urandom, $urandom,
                     $urandom, int'($urandom_range(0, 4)));
            do_txn(t, o);
            compare($sformatf("rnd%0d", i), o, model(t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
